// File: rtl/keypad_pkg.sv
// Shared types and constants for the 4x4 keypad scanner.
package keypad_pkg;

    localparam int NUM_ROWS = 4;
    localparam int NUM_COLS = 4;
    localparam int CODE_W   = 4;
    localparam logic [NUM_ROWS-1:0] ROWS_IDLE = 4'hF;

    typedef enum logic [1:0] {
        StScan,
        StDebounce,
        StPressed
    } state_e;

    typedef logic [CODE_W-1:0] key_code_t;

    // Index of the lowest active-low row; rows must not be all idle.
    function automatic logic [1:0] lowest_low(input logic [NUM_ROWS-1:0] rows);
        lowest_low = 2'd0;
        for (int i = NUM_ROWS - 1; i >= 0; i--) begin
            if (!rows[i]) lowest_low = 2'(i);
        end
    endfunction

endpackage

// File: rtl/scan_tick_gen.sv
// Free-running divider: one-cycle tick every SCAN_DIV clkin cycles.
module scan_tick_gen #(
    parameter int unsigned SCAN_DIV = 50000
) (
    input  logic clkin,
    input  logic rst_n,
    output logic tick
);

    localparam int unsigned DivW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam logic [DivW-1:0] DivMax = DivW'(SCAN_DIV - 1);

    logic [DivW-1:0] div_q, div_d;

    assign tick = (div_q == DivMax);

    always_comb begin
        div_d = tick ? '0 : div_q + 1'b1;
    end

    always_ff @(posedge clkin or negedge rst_n) begin
        if (!rst_n) div_q <= '0;
        else        div_q <= div_d;
    end

endmodule

// File: rtl/keypad_scan.sv
// 4x4 keypad scanner with press/release debounce.
// Optional auto-repeat while held is built when KEY_REPEAT_EN is defined.
module keypad_scan
    import keypad_pkg::*;
#(
    parameter int unsigned SCAN_DIV       = 50000,
    parameter int unsigned DEBOUNCE_TICKS = 4,
    parameter int unsigned REPEAT_DELAY   = 500,
    parameter int unsigned REPEAT_RATE    = 100
) (
    input  logic                clkin,
    input  logic                rst_n,
    input  logic [NUM_ROWS-1:0] row,
    output logic [NUM_COLS-1:0] col,
    output key_code_t           key_code,
    output logic                key_valid,
    output logic                key_pressed
);

    localparam int unsigned CntW = $clog2(DEBOUNCE_TICKS + 1);
    localparam logic [CntW-1:0] CntMax = CntW'(DEBOUNCE_TICKS);

    logic                tick;
    logic [NUM_ROWS-1:0] row_meta_q, row_s_q;
    state_e              state_q, state_d;
    logic [1:0]          col_idx_q, col_idx_d, row_idx_q, row_idx_d;
    logic [CntW-1:0]     cnt_q, cnt_d, rel_q, rel_d;
    key_code_t           key_code_q, key_code_d;
    logic                valid_q, valid_d, pressed_q, pressed_d;
    logic                accept, repeat_pulse;
    logic [1:0]          acc_row;

    scan_tick_gen #(
        .SCAN_DIV(SCAN_DIV)
    ) u_tick (
        .clkin(clkin),
        .rst_n(rst_n),
        .tick (tick)
    );

    always_comb begin
        state_d    = state_q;
        col_idx_d  = col_idx_q;
        row_idx_d  = row_idx_q;
        cnt_d      = cnt_q;
        rel_d      = rel_q;
        key_code_d = key_code_q;
        pressed_d  = pressed_q;
        valid_d    = 1'b0;
        accept     = 1'b0;
        acc_row    = row_idx_q;
        unique case (state_q)
            StScan: if (tick) begin
                if (row_s_q == ROWS_IDLE) begin
                    col_idx_d = col_idx_q + 2'd1;
                end else begin
                    row_idx_d = lowest_low(row_s_q);
                    acc_row   = row_idx_d;
                    cnt_d     = CntW'(1);
                    if (DEBOUNCE_TICKS <= 1) accept = 1'b1;
                    else                     state_d = StDebounce;
                end
            end
            StDebounce: if (tick) begin
                if (!row_s_q[row_idx_q]) begin
                    cnt_d = cnt_q + 1'b1;
                    if (cnt_d == CntMax) accept = 1'b1;
                end else begin
                    state_d   = StScan;
                    col_idx_d = col_idx_q + 2'd1;
                end
            end
            StPressed: if (tick) begin
                if (!row_s_q[row_idx_q]) begin
                    rel_d = '0;
                end else begin
                    rel_d = rel_q + 1'b1;
                    if (rel_d == CntMax) begin
                        pressed_d = 1'b0;
                        state_d   = StScan;
                        col_idx_d = col_idx_q + 2'd1;
                    end
                end
                // A repeat due on the same tick the release is accepted is dropped.
                if (state_d == StPressed && repeat_pulse) valid_d = 1'b1;
            end
            default: state_d = StScan;
        endcase
        if (accept) begin
            key_code_d = {acc_row, col_idx_q};
            valid_d    = 1'b1;
            pressed_d  = 1'b1;
            rel_d      = '0;
            state_d    = StPressed;
        end
    end

`ifdef KEY_REPEAT_EN
    localparam int unsigned HoldW = $clog2(REPEAT_DELAY + 1);
    localparam int unsigned RateW = $clog2(REPEAT_RATE + 1);
    localparam logic [HoldW-1:0] HoldMax = HoldW'(REPEAT_DELAY);
    localparam logic [RateW-1:0] RateMax = RateW'(REPEAT_RATE);

    logic [HoldW-1:0] hold_q, hold_d;
    logic [RateW-1:0] rate_q, rate_d;

    // Hold timer saturates at REPEAT_DELAY; the rate timer then takes over.
    always_comb begin
        hold_d       = hold_q;
        rate_d       = rate_q;
        repeat_pulse = 1'b0;
        if (state_q != StPressed) begin
            hold_d = '0;
            rate_d = '0;
        end else if (tick) begin
            if (hold_q != HoldMax) begin
                hold_d       = hold_q + 1'b1;
                repeat_pulse = (hold_d == HoldMax);
            end else begin
                rate_d = rate_q + 1'b1;
                if (rate_d == RateMax) begin
                    rate_d       = '0;
                    repeat_pulse = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clkin or negedge rst_n) begin
        if (!rst_n) begin
            hold_q <= '0;
            rate_q <= '0;
        end else begin
            hold_q <= hold_d;
            rate_q <= rate_d;
        end
    end
`else
    logic unused_repeat;
    assign unused_repeat = ^{REPEAT_DELAY, REPEAT_RATE};
    assign repeat_pulse  = 1'b0;
`endif

    always_ff @(posedge clkin or negedge rst_n) begin
        if (!rst_n) begin
            row_meta_q <= ROWS_IDLE;
            row_s_q    <= ROWS_IDLE;
            state_q    <= StScan;
            col_idx_q  <= 2'd0;
            row_idx_q  <= 2'd0;
            cnt_q      <= '0;
            rel_q      <= '0;
            key_code_q <= '0;
            valid_q    <= 1'b0;
            pressed_q  <= 1'b0;
        end else begin
            row_meta_q <= row;
            row_s_q    <= row_meta_q;
            state_q    <= state_d;
            col_idx_q  <= col_idx_d;
            row_idx_q  <= row_idx_d;
            cnt_q      <= cnt_d;
            rel_q      <= rel_d;
            key_code_q <= key_code_d;
            valid_q    <= valid_d;
            pressed_q  <= pressed_d;
        end
    end

    assign col         = ~(4'b0001 << col_idx_q);
    assign key_code    = key_code_q;
    assign key_valid   = valid_q;
    assign key_pressed = pressed_q;

endmodule

// File: tb/tb_keypad_scan.sv
// Self-checking bench for keypad_scan: directed table, corner sequences, random vs. model.
module tb_keypad_scan;

    localparam int unsigned SCAN_DIV = 4;
    localparam int unsigned DT = 3;
    localparam int unsigned RD = 5;
    localparam int unsigned RR = 2;
`ifdef KEY_REPEAT_EN
    localparam bit Rep = 1'b1;
`else
    localparam bit Rep = 1'b0;
`endif

    logic        clkin = 1'b0;
    logic        rst_n;
    logic [3:0]  row, col, key_code;
    logic        key_valid, key_pressed;
    logic [15:0] keys;

    int n_cmp = 0;
    int n_bad = 0;

    keypad_scan #(
        .SCAN_DIV      (SCAN_DIV),
        .DEBOUNCE_TICKS(DT),
        .REPEAT_DELAY  (RD),
        .REPEAT_RATE   (RR)
    ) dut (
        .clkin      (clkin),
        .rst_n      (rst_n),
        .row        (row),
        .col        (col),
        .key_code   (key_code),
        .key_valid  (key_valid),
        .key_pressed(key_pressed)
    );

    always #5 clkin = ~clkin;

    // Physical matrix: a closed key pulls its row low when its column is driven low.
    always_comb begin
        row = 4'hF;
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < 4; c++) begin
                if (keys[r*4+c] && !col[c]) row[r] = 1'b0;
            end
        end
    end

    typedef struct {
        logic [15:0] keys;
        logic [3:0]  col;
        logic        v;
        logic [3:0]  code;
        logic        p;
    } vec_t;

    vec_t tbl[30];

    // Reference model state, advanced once per scan tick.
    int m_ph, m_col, m_row, m_hits, m_rel, m_hold, m_code, m_p;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        repeat (2) @(negedge clkin);
        check("reset_col", col, 4'b1110);
        check("reset_valid", key_valid, 1'b0);
        check("reset_code", key_code, 4'd0);
        check("reset_pressed", key_pressed, 1'b0);
        rst_n = 1'b1;
    endtask

    // One scan period; the DUT tick falls on the 4th posedge of the window.
    task automatic run_window(input logic [15:0] k, input logic [3:0] e_col, input logic e_v,
                              input logic [3:0] e_code, input logic e_p);
        keys = k;
        for (int i = 0; i < 3; i++) begin
            @(negedge clkin);
            check("valid_between_ticks", key_valid, 1'b0);
            check("col_between_ticks", $countones(~col), 1);
        end
        @(negedge clkin);
        check("col", col, e_col);
        check("valid", key_valid, e_v);
        check("code", key_code, e_code);
        check("pressed", key_pressed, e_p);
    endtask

    task automatic model_init();
        m_ph = 0; m_col = 0; m_row = 0; m_hits = 0; m_rel = 0; m_hold = 0; m_code = 0; m_p = 0;
    endtask

    task automatic model_tick(input logic [15:0] k, output logic strobe);
        logic [3:0] low;
        logic       acc;
        low = 4'b0;
        for (int r = 0; r < 4; r++) low[r] = k[r*4+m_col];
        strobe = 1'b0;
        acc = 1'b0;
        if (m_ph == 0) begin
            if (low == 4'b0) m_col = (m_col + 1) % 4;
            else begin
                for (int r = 3; r >= 0; r--) if (low[r]) m_row = r;
                m_hits = 1;
                if (m_hits >= int'(DT)) acc = 1'b1;
                else m_ph = 1;
            end
        end else if (m_ph == 1) begin
            if (low[m_row]) begin
                m_hits++;
                if (m_hits >= int'(DT)) acc = 1'b1;
            end else begin
                m_ph = 0;
                m_col = (m_col + 1) % 4;
            end
        end else begin
            m_hold++;
            m_rel = low[m_row] ? 0 : m_rel + 1;
            if (m_rel >= int'(DT)) begin
                m_p = 0; m_ph = 0; m_col = (m_col + 1) % 4;
            end else if (Rep && m_hold >= int'(RD) && (m_hold - int'(RD)) % int'(RR) == 0) begin
                strobe = 1'b1;
            end
        end
        if (acc) begin
            m_code = m_row * 4 + m_col;
            strobe = 1'b1; m_p = 1; m_ph = 2; m_rel = 0; m_hold = 0;
        end
    endtask

    initial begin
        logic        s;
        logic [15:0] k;
        rst_n = 1'b0;
        keys  = 16'h0;

        // Idle scan, key 9 press/hold/release, short pulse, multi-row with bounce.
        tbl[0]  = '{16'h0000, 4'b1101, 1'b0, 4'd0, 1'b0};
        tbl[1]  = '{16'h0000, 4'b1011, 1'b0, 4'd0, 1'b0};
        tbl[2]  = '{16'h0000, 4'b0111, 1'b0, 4'd0, 1'b0};
        tbl[3]  = '{16'h0000, 4'b1110, 1'b0, 4'd0, 1'b0};
        tbl[4]  = '{16'h0200, 4'b1101, 1'b0, 4'd0, 1'b0};
        tbl[5]  = '{16'h0200, 4'b1101, 1'b0, 4'd0, 1'b0};
        tbl[6]  = '{16'h0200, 4'b1101, 1'b0, 4'd0, 1'b0};
        tbl[7]  = '{16'h0200, 4'b1101, 1'b1, 4'd9, 1'b1};
        tbl[8]  = '{16'h0200, 4'b1101, 1'b0, 4'd9, 1'b1};
        tbl[9]  = '{16'h0200, 4'b1101, 1'b0, 4'd9, 1'b1};
        tbl[10] = '{16'h0000, 4'b1101, 1'b0, 4'd9, 1'b1};
        tbl[11] = '{16'h0000, 4'b1101, 1'b0, 4'd9, 1'b1};
        tbl[12] = '{16'h0000, 4'b1011, 1'b0, 4'd9, 1'b0};
        tbl[13] = '{16'h0000, 4'b0111, 1'b0, 4'd9, 1'b0};
        tbl[14] = '{16'h0000, 4'b1110, 1'b0, 4'd9, 1'b0};
        tbl[15] = '{16'h0200, 4'b1101, 1'b0, 4'd9, 1'b0};
        tbl[16] = '{16'h0200, 4'b1101, 1'b0, 4'd9, 1'b0};
        tbl[17] = '{16'h0200, 4'b1101, 1'b0, 4'd9, 1'b0};
        tbl[18] = '{16'h0000, 4'b1011, 1'b0, 4'd9, 1'b0};
        tbl[19] = '{16'h1010, 4'b0111, 1'b0, 4'd9, 1'b0};
        tbl[20] = '{16'h1010, 4'b1110, 1'b0, 4'd9, 1'b0};
        tbl[21] = '{16'h1010, 4'b1110, 1'b0, 4'd9, 1'b0};
        tbl[22] = '{16'h1010, 4'b1110, 1'b0, 4'd9, 1'b0};
        tbl[23] = '{16'h1010, 4'b1110, 1'b1, 4'd4, 1'b1};
        tbl[24] = '{16'h1000, 4'b1110, 1'b0, 4'd4, 1'b1};
        tbl[25] = '{16'h1000, 4'b1110, 1'b0, 4'd4, 1'b1};
        tbl[26] = '{16'h1010, 4'b1110, 1'b0, 4'd4, 1'b1};
        tbl[27] = '{16'h1000, 4'b1110, 1'b0, 4'd4, 1'b1};
        tbl[28] = '{16'h1000, 4'b1110, Rep,  4'd4, 1'b1};
        tbl[29] = '{16'h1000, 4'b1101, 1'b0, 4'd4, 1'b0};

        do_reset();
        for (int i = 0; i < 30; i++) begin
            run_window(tbl[i].keys, tbl[i].col, tbl[i].v, tbl[i].code, tbl[i].p);
        end

        // Asynchronous reset while pressed, then re-detection of the held key.
        do_reset();
        for (int i = 0; i < 3; i++) run_window(16'h0020, 4'b1101, 1'b0, 4'd0, 1'b0);
        run_window(16'h0020, 4'b1101, 1'b1, 4'd5, 1'b1);
        @(posedge clkin);
        #2 rst_n = 1'b0;
        #1;
        check("async_rst_col", col, 4'b1110);
        check("async_rst_valid", key_valid, 1'b0);
        check("async_rst_code", key_code, 4'd0);
        check("async_rst_pressed", key_pressed, 1'b0);
        @(negedge clkin);
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) run_window(16'h0020, 4'b1101, 1'b0, 4'd0, 1'b0);
        run_window(16'h0020, 4'b1101, 1'b1, 4'd5, 1'b1);

        // Long hold of key 0: repeats only when the feature is built.
        do_reset();
        run_window(16'h0001, 4'b1110, 1'b0, 4'd0, 1'b0);
        run_window(16'h0001, 4'b1110, 1'b0, 4'd0, 1'b0);
        run_window(16'h0001, 4'b1110, 1'b1, 4'd0, 1'b1);
        for (int h = 1; h <= 12; h++) begin
            run_window(16'h0001, 4'b1110, Rep && (h == 5 || h == 7 || h == 9 || h == 11),
                       4'd0, 1'b1);
        end
        run_window(16'h0000, 4'b1110, Rep, 4'd0, 1'b1);
        run_window(16'h0000, 4'b1110, 1'b0, 4'd0, 1'b1);
        run_window(16'h0000, 4'b1101, 1'b0, 4'd0, 1'b0);

        // Random key activity against the reference model.
        do_reset();
        model_init();
        k = 16'h0;
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 4) == 0) begin
                case ($urandom_range(0, 3))
                    0:       k = 16'h0;
                    1, 2:    k = 16'h1 << $urandom_range(0, 15);
                    default: k = (16'h1 << $urandom_range(0, 15)) | (16'h1 << $urandom_range(0, 15));
                endcase
            end
            model_tick(k, s);
            run_window(k, ~(4'b0001 << m_col), s, 4'(m_code), m_p[0]);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
